// File: rtl/fp_mul_pipe.sv
// ---------------------------------------------------------------------------
// fp_mul_pipe -- parametrised 3-stage floating-point multiplier
//
// Purpose:
//   Multiplies two IEEE-754-style operands {sign, exponent, fraction}.
//   S1 unpacks and classifies the operands and forms the biased exponent sum.
//   S2 multiplies the significands. S3 normalises, rounds to nearest-even and
//   packs the result. Subnormal inputs are treated as zero and subnormal
//   results are flushed to zero.
//
// Parameters:
//   EXP_W   exponent field width (>=3), BIAS = 2^(EXP_W-1)-1
//   FRAC_W  stored fraction width (>=2)
//   W       1+EXP_W+FRAC_W, derived
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   input_a    operand A
//   input_b    operand B
//   in_valid   operands valid this cycle
//   in_ready   block accepts operands this cycle
//   output_z   registered product
//   out_valid  output_z holds a result
//   out_ready  consumer accepts output_z this cycle
//   flags      {invalid, overflow, underflow, inexact}, registered with
//              output_z; present only when FP_MUL_FLAGS_EN is defined
//
// Configuration macro: FP_MUL_FLAGS_EN
//
// Flow control: one global enable (adv = !out_valid | out_ready) moves every
// stage at once, so results leave in issue order and all stages hold together
// under back-pressure.
// ---------------------------------------------------------------------------
module fp_mul_pipe #(
  parameter  int EXP_W  = 8,
  parameter  int FRAC_W = 23,
  localparam int W      = 1 + EXP_W + FRAC_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] input_a,
  input  logic [W-1:0] input_b,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] output_z,
  output logic         out_valid,
  input  logic         out_ready
`ifdef FP_MUL_FLAGS_EN
  ,
  output logic [3:0]   flags
`endif
);

  localparam int SIG_W  = FRAC_W + 1;
  localparam int PROD_W = 2 * SIG_W;
  // Two extra bits hold the exponent sum without wrapping: one for the
  // carry above 2^EXP_W and one for the sign when the sum goes negative.
  localparam int EXS_W  = EXP_W + 2;
  localparam int BIAS   = (1 << (EXP_W - 1)) - 1;
  localparam logic [EXS_W-1:0] EXP_MAX = EXS_W'((1 << EXP_W) - 1);

  typedef enum logic [1:0] {
    SP_NONE,
    SP_ZERO,
    SP_INF,
    SP_NAN
  } special_e;

  // ---------------------------------------------------------------- control
  logic w_adv;
  assign w_adv    = !out_valid | out_ready;
  assign in_ready = w_adv;

  // ---------------------------------------------------------------- S1 comb
  logic              w_sa, w_sb;
  logic [EXP_W-1:0]  w_ea, w_eb;
  logic [FRAC_W-1:0] w_fa, w_fb;
  logic              w_a_zero, w_a_inf, w_a_nan;
  logic              w_b_zero, w_b_inf, w_b_nan;
  special_e          w_special;
  logic [EXS_W-1:0]  w_exp_sum;

  assign {w_sa, w_ea, w_fa} = input_a;
  assign {w_sb, w_eb, w_fb} = input_b;

  // Exponent 0 covers both true zero and subnormals; both are taken as zero.
  assign w_a_zero = (w_ea == '0);
  assign w_b_zero = (w_eb == '0);
  assign w_a_inf  = (w_ea == '1) && (w_fa == '0);
  assign w_b_inf  = (w_eb == '1) && (w_fb == '0);
  assign w_a_nan  = (w_ea == '1) && (w_fa != '0);
  assign w_b_nan  = (w_eb == '1) && (w_fb != '0);

  // Two's-complement sum in EXS_W bits; a negative result shows as MSB=1.
  assign w_exp_sum = EXS_W'(w_ea) + EXS_W'(w_eb) - EXS_W'(BIAS);

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    w_special = SP_NONE;
    if (w_a_nan || w_b_nan || (w_a_inf && w_b_zero) || (w_a_zero && w_b_inf))
      w_special = SP_NAN;
    else if (w_a_inf || w_b_inf)
      w_special = SP_INF;
    else if (w_a_zero || w_b_zero)
      w_special = SP_ZERO;
  end

  // ------------------------------------------------------ pipeline registers
  logic              r_v1, r_v2;
  logic              r1_sign, r2_sign;
  special_e          r1_special, r2_special;
  logic [SIG_W-1:0]  r1_sig_a, r1_sig_b;
  logic [EXS_W-1:0]  r1_exp, r2_exp;
  logic [PROD_W-1:0] r2_prod;

  // NOTE: datapath registers carry no reset; their contents only matter when
  // the matching valid bit is set, and the valid bits are reset.
  always_ff @(posedge clk) begin
    if (w_adv) begin
      r1_sign    <= w_sa ^ w_sb;
      r1_special <= w_special;
      r1_sig_a   <= {1'b1, w_fa};
      r1_sig_b   <= {1'b1, w_fb};
      r1_exp     <= w_exp_sum;

      r2_sign    <= r1_sign;
      r2_special <= r1_special;
      r2_prod    <= r1_sig_a * r1_sig_b;
      r2_exp     <= r1_exp;
    end
  end

  // ---------------------------------------------------------------- S3 comb
  logic [SIG_W-1:0]  w_mant;
  logic              w_guard, w_sticky, w_round_up;
  logic [SIG_W:0]    w_mant_rnd;
  logic [EXS_W-1:0]  w_exp_norm, w_exp_fin;
  logic [FRAC_W-1:0] w_frac;
  logic              w_ovf, w_unf;
  logic [W-1:0]      w_z;

  always_comb begin
    // Product of two [1,2) significands lies in [1,4); MSB set means >= 2.
    if (r2_prod[PROD_W-1]) begin
      w_mant     = r2_prod[PROD_W-1 -: SIG_W];
      w_guard    = r2_prod[FRAC_W];
      w_sticky   = |r2_prod[FRAC_W-1:0];
      w_exp_norm = r2_exp + EXS_W'(1);
    end else begin
      w_mant     = r2_prod[PROD_W-2 -: SIG_W];
      w_guard    = r2_prod[FRAC_W-1];
      w_sticky   = |r2_prod[FRAC_W-2:0];
      w_exp_norm = r2_exp;
    end

    // Nearest-even: round up above the halfway point, or on a tie when odd.
    w_round_up = w_guard & (w_sticky | w_mant[0]);
    w_mant_rnd = {1'b0, w_mant} + (SIG_W + 1)'(w_round_up);

    // Carry out of the significand: value became exactly 2.0 * 2^e.
    if (w_mant_rnd[SIG_W]) begin
      w_exp_fin = w_exp_norm + EXS_W'(1);
      w_frac    = '0;
    end else begin
      w_exp_fin = w_exp_norm;
      w_frac    = w_mant_rnd[FRAC_W-1:0];
    end

    w_ovf = !w_exp_fin[EXS_W-1] && (w_exp_fin >= EXP_MAX);
    w_unf = w_exp_fin[EXS_W-1] || (w_exp_fin == '0);

    unique case (r2_special)
      SP_NAN:  w_z = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W - 1){1'b0}}};
      SP_INF:  w_z = {r2_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      SP_ZERO: w_z = {r2_sign, {(W - 1){1'b0}}};
      default: begin
        if (w_ovf)
          w_z = {r2_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
        else if (w_unf)
          w_z = {r2_sign, {(W - 1){1'b0}}};
        else
          w_z = {r2_sign, w_exp_fin[EXP_W-1:0], w_frac};
      end
    endcase
  end

`ifdef FP_MUL_FLAGS_EN
  logic       w_normal;
  logic [3:0] w_flags;
  assign w_normal = (r2_special == SP_NONE);
  assign w_flags  = {r2_special == SP_NAN,
                     w_normal & w_ovf,
                     w_normal & w_unf,
                     w_normal & (w_guard | w_sticky | w_ovf | w_unf)};
`endif

  // ---------------------------------------------------- valid bits / output
  // NOTE: sequential state uses non-blocking assignments so every stage sees
  // the previous cycle's value of the stage before it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1      <= 1'b0;
      r_v2      <= 1'b0;
      out_valid <= 1'b0;
      output_z  <= '0;
`ifdef FP_MUL_FLAGS_EN
      flags     <= '0;
`endif
    end else if (w_adv) begin
      r_v1      <= in_valid;
      r_v2      <= r_v1;
      out_valid <= r_v2;
      // Only real results are loaded, so output_z never shows bubble data.
      if (r_v2) begin
        output_z <= w_z;
`ifdef FP_MUL_FLAGS_EN
        flags    <= w_flags;
`endif
      end
    end
  end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// ---------------------------------------------------------------------------
// tb_fp_mul_pipe -- scoreboard bench for fp_mul_pipe
//
// Two instances: fp32 defaults (u_dut) and an fp16 build (u_dut_h,
// EXP_W=5, FRAC_W=10). Stimulus tasks push hand-computed expectations into a
// queue per instance; monitor processes pop and compare whenever the DUT
// presents a result. Flag checks are compiled in with FP_MUL_FLAGS_EN.
// ---------------------------------------------------------------------------
module tb_fp_mul_pipe;

  localparam int W  = 32;
  localparam int HW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  in_a, in_b, output_z;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [HW-1:0] h_a, h_b, h_z;
  logic          h_valid, h_in_ready, h_out_valid, h_out_ready;
`ifdef FP_MUL_FLAGS_EN
  logic [3:0]    flags, h_flags;
`endif

  always #5 clk = ~clk;

  fp_mul_pipe u_dut (
    .clk       (clk),
    .rst       (rst),
    .input_a   (in_a),
    .input_b   (in_b),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .output_z  (output_z),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef FP_MUL_FLAGS_EN
    ,
    .flags     (flags)
`endif
  );

  fp_mul_pipe #(.EXP_W(5), .FRAC_W(10)) u_dut_h (
    .clk       (clk),
    .rst       (rst),
    .input_a   (h_a),
    .input_b   (h_b),
    .in_valid  (h_valid),
    .in_ready  (h_in_ready),
    .output_z  (h_z),
    .out_valid (h_out_valid),
    .out_ready (h_out_ready)
`ifdef FP_MUL_FLAGS_EN
    ,
    .flags     (h_flags)
`endif
  );

  typedef struct {
    logic [31:0] z;
    logic [3:0]  f;
    int          issue_cyc;
    bit          lat;
    string       name;
  } exp_t;

  exp_t sb[$];
  exp_t sb_h[$];
  exp_t mon_e, mon_eh;

  int total     = 0;
  int bad       = 0;
  int cyc       = 0;
  int seen      = 0;
  int valid_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, expv);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s", name);
  endtask

  // ------------------------------------------------------------- monitors
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      valid_cnt++;
      if (sb.size() == 0) begin
        fail_now("unexpected_output");
      end else if (out_ready) begin
        mon_e = sb.pop_front();
        seen++;
        check(mon_e.name, output_z, mon_e.z);
`ifdef FP_MUL_FLAGS_EN
        check({mon_e.name, "_flags"}, {28'd0, flags}, {28'd0, mon_e.f});
`endif
        if (mon_e.lat)
          check({mon_e.name, "_latency"}, cyc, mon_e.issue_cyc + 3);
      end else begin
        check({sb[0].name, "_hold"}, output_z, sb[0].z);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && h_out_valid) begin
      if (sb_h.size() == 0) begin
        fail_now("h_unexpected_output");
      end else if (h_out_ready) begin
        mon_eh = sb_h.pop_front();
        check(mon_eh.name, {16'd0, h_z}, mon_eh.z);
`ifdef FP_MUL_FLAGS_EN
        check({mon_eh.name, "_flags"}, {28'd0, h_flags}, {28'd0, mon_eh.f});
`endif
      end
    end
  end

  // ------------------------------------------------------------- stimulus
  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] z, input logic [3:0] f,
                       input string name, input bit lat);
    int   waited;
    exp_t e;
    waited   = 0;
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    while (!in_ready && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      fail_now({name, "_accept_timeout"});
    end else begin
      e.z = z; e.f = f; e.issue_cyc = cyc; e.lat = lat; e.name = name;
      sb.push_back(e);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic issue_h(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] z, input logic [3:0] f,
                         input string name);
    exp_t e;
    h_a     = a;
    h_b     = b;
    h_valid = 1'b1;
    if (!h_in_ready) begin
      fail_now({name, "_not_ready"});
    end else begin
      e.z = {16'd0, z}; e.f = f; e.issue_cyc = cyc; e.lat = 1'b0; e.name = name;
      sb_h.push_back(e);
    end
    @(negedge clk);
    h_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((sb.size() != 0 || sb_h.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({name, "_drained"}, sb.size() + sb_h.size(), 0);
  endtask

  // Directed vectors: {a, b, expected z, expected flags}
  typedef struct {
    logic [31:0] a, b, z;
    logic [3:0]  f;
    string       name;
  } vec_t;

  vec_t vecs[] = '{
    '{32'hC0400000, 32'h40000000, 32'hC0C00000, 4'b0000, "neg3x2"},
    '{32'h3FC00000, 32'h3FC00000, 32'h40100000, 4'b0000, "norm_1p5sq"},
    '{32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001, "inexact_sticky"},
    '{32'h3F800001, 32'h3FC00000, 32'h3FC00002, 4'b0001, "tie_odd_up"},
    '{32'h3F800003, 32'h3FC00000, 32'h3FC00004, 4'b0001, "tie_even_hold"},
    '{32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000, "inf_x_zero"},
    '{32'h7F800001, 32'h3F800000, 32'h7FC00000, 4'b1000, "nan_in"},
    '{32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000, "neg_inf"},
    '{32'h00400000, 32'h40000000, 32'h00000000, 4'b0000, "subnorm_zero"},
    '{32'h80000000, 32'h40000000, 32'h80000000, 4'b0000, "neg_zero"},
    '{32'h7F000000, 32'h40000000, 32'h7F800000, 4'b0101, "overflow"},
    '{32'h00800000, 32'h3F000000, 32'h00000000, 4'b0011, "underflow"}
  };

  vec_t bp_vecs[] = '{
    '{32'h3F800000, 32'h3F800000, 32'h3F800000, 4'b0000, "bp0_1x1"},
    '{32'h40000000, 32'h40000000, 32'h40800000, 4'b0000, "bp1_2x2"},
    '{32'h3F000000, 32'h3F000000, 32'h3E800000, 4'b0000, "bp2_halfsq"},
    '{32'hBFC00000, 32'h40000000, 32'hC0400000, 4'b0000, "bp3_neg1p5x2"},
    '{32'h40400000, 32'h40400000, 32'h41100000, 4'b0000, "bp4_3x3"}
  };

  int base;

  initial begin
    rst         = 1'b1;
    in_valid    = 1'b0;
    in_a        = '0;
    in_b        = '0;
    out_ready   = 1'b1;
    h_valid     = 1'b0;
    h_a         = '0;
    h_b         = '0;
    h_out_ready = 1'b1;

    repeat (2) @(negedge clk);
    check("reset_out_valid", {31'd0, out_valid}, 0);
    check("reset_output_z", output_z, 0);
`ifdef FP_MUL_FLAGS_EN
    check("reset_flags", {28'd0, flags}, 0);
`endif
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);

    // Single isolated op with latency check.
    issue(32'h40400000, 32'h40000000, 32'h40C00000, 4'b0000, "3x2", 1'b1);
    repeat (5) @(negedge clk);

    // Back-to-back directed vectors.
    foreach (vecs[i])
      issue(vecs[i].a, vecs[i].b, vecs[i].z, vecs[i].f, vecs[i].name, 1'b0);
    wait_drain("directed");

    // Back-pressure: five ops while the consumer stalls.
    @(posedge clk);
    #2 out_ready = 1'b0;
    @(negedge clk);
    base = seen;
    fork
      begin
        foreach (bp_vecs[i])
          issue(bp_vecs[i].a, bp_vecs[i].b, bp_vecs[i].z, bp_vecs[i].f,
                bp_vecs[i].name, 1'b0);
      end
      begin
        repeat (5) @(negedge clk);
        check("bp_in_ready_low", {31'd0, in_ready}, 0);
        check("bp_out_valid_high", {31'd0, out_valid}, 1);
        @(posedge clk);
        #2 out_ready = 1'b1;
      end
    join
    wait_drain("bp");
    check("bp_count", seen - base, 5);

    // Reset with three operations in flight.
    @(posedge clk);
    #2 out_ready = 1'b0;
    @(negedge clk);
    issue(32'h40400000, 32'h40000000, 32'h40C00000, 4'b0000, "rf0", 1'b0);
    issue(32'h3FC00000, 32'h3FC00000, 32'h40100000, 4'b0000, "rf1", 1'b0);
    issue(32'h40000000, 32'h40000000, 32'h40800000, 4'b0000, "rf2", 1'b0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_out_valid", {31'd0, out_valid}, 0);
    check("rst_mid_output_z", output_z, 0);
`ifdef FP_MUL_FLAGS_EN
    check("rst_mid_flags", {28'd0, flags}, 0);
`endif
    sb.delete();
    @(posedge clk);
    #2 rst = 1'b0;
    out_ready = 1'b1;
    base = valid_cnt;
    repeat (10) @(negedge clk);
    check("no_stale_output", valid_cnt - base, 0);
    issue(32'h3FC00000, 32'h3FC00000, 32'h40100000, 4'b0000, "after_rst", 1'b0);
    wait_drain("after_rst");

    // fp16 build.
    issue_h(16'h4200, 16'h4000, 16'h4600, 4'b0000, "h_3x2");
    issue_h(16'hC200, 16'h4000, 16'hC600, 4'b0000, "h_neg3x2");
    issue_h(16'h7C00, 16'h0000, 16'h7E00, 4'b1000, "h_inf_x_zero");
    issue_h(16'h7800, 16'h4000, 16'h7C00, 4'b0101, "h_overflow");
    wait_drain("h");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fp_mul_pipe.md
Name: fp_mul_pipe

Overview:
Parametrised, pipelined IEEE-754-style floating-point multiplier. Generalises the single-precision field-unpack / exponent-sum front end into a complete 3-stage datapath: unpack, mantissa multiply, normalise/round/pack. Exponent and fraction widths are configurable, so the same block serves fp16, bf16 and fp32. Sits between operand issue logic and the result writeback path, with valid/ready flow control on both sides.

Parameters:
EXP_W, 8, exponent field width (>=3); BIAS = 2^(EXP_W-1)-1
FRAC_W, 23, stored fraction width (>=2); significand = FRAC_W+1 bits with hidden bit
W is derived as 1+EXP_W+FRAC_W (not overridable).

Ports:
clk  input  1  clock, all flops on rising edge
rst  input  1  asynchronous, active-high reset
input_a  input  W  operand A {sign, exponent, fraction}
input_b  input  W  operand B
in_valid  input  1  operands valid this cycle
in_ready  output  1  block accepts operands this cycle
output_z  output  W  product
out_valid  output  1  output_z holds a result
out_ready  input  1  consumer accepts output_z this cycle
flags  output  4  {invalid, overflow, underflow, inexact}; present only with FP_MUL_FLAGS_EN

Behaviour:
- Reset (async, rst=1): all stage valid bits, out_valid and output_z (and flags) are 0. In-flight operations are discarded. No output appears until new input is accepted after rst deasserts.
- Pipeline: 3 register stages (S1 unpack, S2 multiply, S3 round/pack). Latency from an accepted input (in_valid & in_ready) to out_valid is exactly 3 cycles when there is no stall.
- Flow control: global enable adv = !out_valid | out_ready; in_ready = adv. When adv=0 every stage holds. Results leave in issue order. Throughput is 1 per cycle when out_ready=1. A bubble is an invalid stage that still advances.
- S1:
  - sign = sa ^ sb.
  - Classify each operand as zero (exp=0; subnormals are treated as zero), inf (exp all ones, frac=0), nan (exp all ones, frac!=0) or normal.
  - Significand = {1, frac}.
  - exp_sum = ea + eb - BIAS, computed signed in EXP_W+2 bits (no wrap).
- S2: product = sig_a * sig_b, width 2*(FRAC_W+1). Special-case tag and sign are carried alongside.
- S3:
  - If the product MSB is 1: exp_sum+1, use the upper bits. Otherwise use the bits one position lower.
  - Round to nearest, ties to even, using guard bit plus sticky (OR of the remaining bits).
  - A rounding carry out of the significand increments the exponent and sets the fraction to 0.
- Final exponent >= 2^EXP_W-1: overflow -> signed inf (exp all ones, frac 0).
- Final exponent <= 0: underflow -> signed zero (flush, no subnormal output).
- Specials, with priority top-down:
  - any NaN, or inf*zero -> canonical qNaN (sign 0, exp all ones, frac MSB 1, rest 0);
  - inf*(inf|normal) -> signed inf;
  - zero*(zero|normal) -> signed zero.
- output_z is registered and holds stable while out_valid & !out_ready.

Optional Feature:
- Macro FP_MUL_FLAGS_EN.
- Defined:
  - flags port exists and is registered with output_z, with the same stall/hold behaviour.
  - invalid = NaN input or inf*0.
  - overflow = normal-path overflow to inf.
  - underflow = normal-path flush to zero.
  - inexact = guard|sticky nonzero, or overflow, or underflow.
  - Special-case inf/zero results do not raise overflow/underflow.
  - flags reset to 0.
- Undefined: port and logic absent; output_z behaviour identical.

Test Plan:
- Defaults. 0x40400000 * 0x40000000 (3.0*2.0), in_valid one cycle, out_ready=1 -> out_valid exactly 3 cycles later, output_z=0x40C00000. Also 0xC0400000*0x40000000 -> 0xC0C00000.
- Normalise and round: 0x3FC00000*0x3FC00000 -> 0x40100000 (2.25). 0x3F800001*0x3F800001 -> 0x3F800002, inexact=1.
- Specials:
  - 0x7F800000*0x00000000 -> 0x7FC00000, invalid=1;
  - 0xFF800000*0x40000000 -> 0xFF800000;
  - 0x00400000 (subnormal)*0x40000000 -> 0x00000000.
- Range: 0x7F000000*0x40000000 -> 0x7F800000, overflow=1. 0x00800000*0x3F000000 -> 0x00000000, underflow=1.
- Backpressure: 5 back-to-back inputs with out_ready=0 -> in_ready drops after the pipe fills, output_z held stable. Raising out_ready drains all 5 in order, none lost or duplicated.
- Reset mid-flight: assert rst with 3 ops in flight -> out_valid=0 and output_z=0 immediately. After release, no stale results. Also repeat the first case with EXP_W=5, FRAC_W=10: 0x4200*0x4000 -> 0x4600.
